// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Encodings, state enum and Moore output decode for the
//               multi-cycle MIPS-subset control sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_bad = 4'b1111;

    localparam logic [1:0] c_srcb_rt     = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    localparam logic [1:0] c_pcs_alu    = 2'b00;
    localparam logic [1:0] c_pcs_aluout = 2'b01;
    localparam logic [1:0] c_pcs_jump   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       pc_en;
        logic [1:0] pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [3:0] aluop;
        logic       regdst;
        logic       regwrite;
        logic       mem2reg;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    // State-only part of the control word; the Mealy terms are ORed in by the FSM.
    function automatic ctl_t moore_ctl(input state_t s, input logic [3:0] exec_aluop);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = c_srcb_four;
                c.aluop   = c_alu_add;
                c.pcsource = c_pcs_alu;
            end
            S_DECODE: begin
                c.alusrcb = c_srcb_imm_sh;
                c.extop   = 1'b1;
                c.aluop   = c_alu_add;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = c_srcb_imm;
                c.extop   = 1'b1;
                c.aluop   = c_alu_add;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite   = 1'b1;
                c.mem2reg    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = c_srcb_rt;
                c.aluop   = exec_aluop;
            end
            S_ALUWB: begin
                c.regwrite   = 1'b1;
                c.regdst     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = c_srcb_rt;
                c.aluop      = c_alu_sub;
                c.pcsource   = c_pcs_aluout;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pcsource   = c_pcs_jump;
                c.pc_en      = 1'b1;
                c.instr_done = 1'b1;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Control/status bundle between sequencer (master) and datapath.
// Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pc_en;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [3:0] aluop;
    logic       regdst;
    logic       regwrite;
    logic       mem2reg;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, func, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pc_en, pcsource,
               alusrca, alusrcb, extop, aluop, regdst, regwrite,
               mem2reg, instr_done, illegal
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pc_en, pcsource,
               alusrca, alusrcb, extop, aluop, regdst, regwrite,
               mem2reg, instr_done, illegal
    );

endinterface
`default_nettype wire

// File: rtl/mc_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decode
// Description : R-type func field to ALU operation, with a legality flag.
// Revision    : 1.0  initial release
// ============================================================================
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] func,
    output logic [3:0] aluop,
    output logic       valid
);

    always_comb begin
        aluop = c_alu_bad;
        valid = 1'b1;
        case (func)
            c_fn_add: aluop = c_alu_add;
            c_fn_sub: aluop = c_alu_sub;
            c_fn_and: aluop = c_alu_and;
            c_fn_or:  aluop = c_alu_or;
            c_fn_slt: aluop = c_alu_slt;
            default:  valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore sequencer stepping MIPS-subset instructions through
//               fetch/decode/execute/memory/write-back with a req/ready memory.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
    import mc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_target;
    logic       r_run;
    ctl_t       r_ctl;
    logic [3:0] w_fn_aluop;
    logic       w_fn_valid;
    logic       w_fetch_hit;

    mc_alu_decode u_alu_decode (
        .func  (bus.func),
        .aluop (w_fn_aluop),
        .valid (w_fn_valid)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    c_op_rtype:       w_next = S_EXEC;
                    c_op_lw, c_op_sw: w_next = S_MEMADR;
                    c_op_beq:         w_next = S_BRANCH;
                    c_op_j:           w_next = S_JUMP;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = w_fn_valid ? S_ALUWB : S_TRAP;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // The first edge after reset only arms run; the FETCH outputs appear with it.
    assign w_target = r_run ? w_next : S_FETCH;

    // Control word is registered from the next state, so state-only outputs
    // come straight from flops. The EXEC aluop is captured on DECODE->EXEC,
    // which is safe because the instruction register is already stable then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_ctl   <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_target;
            r_ctl   <= moore_ctl(w_target, w_fn_aluop);
        end
    end

    assign w_fetch_hit = r_run && (r_state == S_FETCH) && bus.mem_ready;

    assign bus.mem_req    = r_ctl.mem_req;
    assign bus.iord       = r_ctl.iord;
    assign bus.memwrite   = r_ctl.memwrite;
    assign bus.irwrite    = w_fetch_hit;
    assign bus.pc_en      = r_ctl.pc_en | w_fetch_hit
                          | (r_run && (r_state == S_BRANCH) && bus.zero);
    assign bus.pcsource   = r_ctl.pcsource;
    assign bus.alusrca    = r_ctl.alusrca;
    assign bus.alusrcb    = r_ctl.alusrcb;
    assign bus.extop      = r_ctl.extop;
    assign bus.aluop      = r_ctl.aluop;
    assign bus.regdst     = r_ctl.regdst;
    assign bus.regwrite   = r_ctl.regwrite;
    assign bus.mem2reg    = r_ctl.mem2reg;
    assign bus.instr_done = r_ctl.instr_done
                          | (r_run && (r_state == S_MEMWR) && bus.mem_ready);
    assign bus.illegal    = r_ctl.illegal;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared register file, ALU, unified instruction/data memory and PC. It replaces the one-shot opcode decode of the single-cycle build, so one memory port and one ALU are reused across cycles. It also handles a variable-latency memory through a req/ready handshake.

## Interface
Parameters:
- none. Encodings are fixed in `mc_pkg`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instr[31:26], taken from the instruction register
- `func`  in  6  instr[5:0], taken from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `mem_req`  out  1  memory access request
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  request is a write
- `irwrite`  out  1  load the instruction register
- `pc_en`  out  1  PC write enable
- `pcsource`  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = rs
- `alusrcb`  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- `extop`  out  1  1 = sign-extend the immediate
- `aluop`  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- `regdst`  out  1  destination register: 1 = rd, 0 = rt
- `regwrite`  out  1  register file write enable
- `mem2reg`  out  1  write-back data: 1 = memory data register, 0 = ALUOut
- `instr_done`  out  1  one-cycle pulse on the final cycle of an instruction
- `illegal`  out  1  sticky flag: unsupported opcode or func seen

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP.
- **Start-up flag `run`:** reset clears `run`. While `run` = 0, every output is 0. `run` sets on the first clock after `rst_n` deasserts.
- **FETCH:**
  - Drive `mem_req` = 1, `iord` = 0, `alusrca` = 0, `alusrcb` = 01, `aluop` = ADD, `pcsource` = 00.
  - Hold in FETCH while `mem_ready` = 0.
  - On the cycle where `mem_ready` = 1: `irwrite` = 1 and `pc_en` = 1 (PC ← PC + 4), then go to DECODE.
- **DECODE:**
  - Compute the branch target: `alusrcb` = 11, `extop` = 1, `aluop` = ADD.
  - Dispatch on `opcode`:
    - 000000 → EXEC
    - 100011 (LW) or 101011 (SW) → MEMADR
    - 000100 (BEQ) → BRANCH
    - 000010 (J) → JUMP
    - any other → TRAP
- **MEMADR:** `alusrca` = 1, `alusrcb` = 10, `extop` = 1, `aluop` = ADD. Go to MEMRD for LW, MEMWR for SW.
- **MEMRD:** `mem_req` = 1, `iord` = 1. Wait for `mem_ready`, then go to MEMWB.
- **MEMWB:** `regwrite` = 1, `regdst` = 0, `mem2reg` = 1, `instr_done` = 1. Go to FETCH.
- **MEMWR:** `mem_req` = 1, `memwrite` = 1, `iord` = 1. On `mem_ready`: `instr_done` = 1, go to FETCH.
- **EXEC:**
  - `alusrca` = 1, `alusrcb` = 00, `aluop` from `func` decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other `func` → TRAP, with `aluop` = 1111 in that cycle. Otherwise go to ALUWB.
- **ALUWB:** `regwrite` = 1, `regdst` = 1, `mem2reg` = 0, `instr_done` = 1. Go to FETCH.
- **BRANCH:**
  - `alusrca` = 1, `alusrcb` = 00, `aluop` = SUB, `pcsource` = 01.
  - `pc_en` = `zero` (combinational).
  - `instr_done` = 1. Go to FETCH.
- **JUMP:** `pcsource` = 10, `pc_en` = 1, `instr_done` = 1. Go to FETCH.
- **TRAP:** `illegal` = 1 and all enables 0. TRAP is absorbing; only `rst_n` exits it.
- **Unlisted outputs** are 0 in every state.

## Timing
- **Reset values:** state = FETCH, `run` = 0, all outputs 0. Reset takes effect immediately on `rst_n` falling, in any state, including mid-handshake.
- **First fetch:** `mem_req` first rises one cycle after the first clock edge with `rst_n` = 1.
- **Cycles per instruction** (zero-wait memory, `mem_ready` = 1 on request): R-type 4, LW 5, SW 4, BEQ 3, J 3.
- **Wait states:** each cycle with `mem_req` = 1 and `mem_ready` = 0 adds exactly one cycle and changes no output.
- **Unsolicited ready:** `mem_ready` is ignored when `mem_req` = 0.
- **Mealy outputs:** `irwrite`, FETCH/BRANCH `pc_en`, and MEMWR `instr_done` depend combinationally on `mem_ready`/`zero`. All other outputs depend only on state.
- **Operand sampling:** `opcode` is sampled in DECODE; `func` is sampled in EXEC. The instruction register is stable from DECODE through the end of the instruction.

## Structure
- **Package `mc_pkg`:** state enum (4-bit), opcode and func constants, `aluop` codes, `alusrcb` and `pcsource` encodings.
- **Sub-module `mc_alu_decode`:** combinational `func` → {`aluop`, valid}. It is instantiated by the FSM and reusable by later pipelined control.

## Test plan
- **Reset / start-up:** hold `rst_n` = 0 for 3 cycles, then release → all outputs 0 throughout reset and on the first cycle after release; `mem_req` = 1 on the second cycle.
- **ADD `$3,$1,$2`** (opcode 000000, func 100000), `mem_ready` held 1 → states FETCH, DECODE, EXEC, ALUWB; `aluop` = 0010 in EXEC; `regwrite` = 1 with `regdst` = 1 in ALUWB; `instr_done` pulses on cycle 4.
- **LW with 2 wait states on each access** → FETCH lasts 3 cycles with `irwrite` only on the third; MEMRD lasts 3 cycles; `regwrite` with `mem2reg` = 1 in MEMWB; total 9 cycles.
- **SW then BEQ:**
  - SW → `memwrite` = 1 with `iord` = 1; `regwrite` never asserts.
  - BEQ with `zero` = 1 → `pc_en` = 1 and `pcsource` = 01 in BRANCH.
  - BEQ with `zero` = 0 → `pc_en` = 0 in BRANCH.
- **J** (000010) → `pcsource` = 10 and `pc_en` = 1 in JUMP; 3-cycle instruction.
- **Illegal instructions:**
  - opcode 111111 → TRAP after DECODE, `illegal` stays 1 for 10+ cycles with `mem_req` = 0.
  - R-type func 000111 → TRAP from EXEC, `regwrite` never asserts.
  - Asserting `rst_n` = 0 during MEMRD → immediate return to FETCH with all outputs 0.
